// File: rtl/mpc_mvmult_pkg.sv
// Shared widths, FSM state encoding and accumulator sizing for the row MAC.
package mpc_mvmult_pkg;

    localparam int COEF_W_DEF = 17;
    localparam int X_W_DEF    = 32;
    localparam int FRAC_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Full product width plus growth for summing n terms
    function automatic int acc_width(input int coef_w, input int x_w, input int n);
        return coef_w + x_w + $clog2(n);
    endfunction

endpackage

// File: rtl/mpc_mvmult_row_mac_if.sv
// Handshake, coefficient-ROM and result signals of one matrix-row MAC.
interface mpc_mvmult_row_mac_if import mpc_mvmult_pkg::*; #(
    parameter int ADDR_W = 3,
    parameter int COEF_W = COEF_W_DEF,
    parameter int X_W    = X_W_DEF
);
    logic              start;
    logic              busy;
    logic [X_W-1:0]    x_data;
    logic              x_valid;
    logic              x_ready;
    logic [ADDR_W-1:0] rom_address0;
    logic              rom_ce0;
    logic [COEF_W-1:0] rom_q0;
    logic [X_W-1:0]    y_data;
    logic              y_valid;
    logic              y_ready;

    modport slave (
        input  start, x_data, x_valid, rom_q0, y_ready,
        output busy, x_ready, rom_address0, rom_ce0, y_data, y_valid
    );

    modport master (
        output start, x_data, x_valid, rom_q0, y_ready,
        input  busy, x_ready, rom_address0, rom_ce0, y_data, y_valid
    );
endinterface

// File: rtl/mpc_mvmult_sat.sv
// Drops FRAC fraction bits from the accumulator and reduces it to X_W bits.
// MPC_MVMULT_SAT_EN defined: clamp to the signed X_W range; undefined: wrap.
module mpc_mvmult_sat #(
    parameter int ACC_W = 52,
    parameter int X_W   = 32,
    parameter int FRAC  = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [X_W-1:0]   y
);

`ifdef MPC_MVMULT_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-X_W+1){1'b1}}, {(X_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc >>> FRAC;

    always_comb begin
        y = shifted[X_W-1:0];
        if (shifted > MAX_V) begin
            y = MAX_V[X_W-1:0];
        end else if (shifted < MIN_V) begin
            y = MIN_V[X_W-1:0];
        end
    end
`else
    assign y = X_W'(acc >>> FRAC);
`endif

endmodule

// File: rtl/mpc_mvmult_row_mac.sv
// One row of a matrix-vector product: streams N elements, multiplies each by
// its ROM coefficient and emits the Q16.16 sum (MPC_MVMULT_SAT_EN: saturate).
module mpc_mvmult_row_mac import mpc_mvmult_pkg::*; #(
    parameter int N      = 8,
    parameter int ADDR_W = 3,
    parameter int COEF_W = COEF_W_DEF,
    parameter int X_W    = X_W_DEF,
    parameter int FRAC   = FRAC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    mpc_mvmult_row_mac_if.slave  bus
);

    localparam int                ACC_W = acc_width(COEF_W, X_W, N);
    localparam int                PRD_W = COEF_W + X_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N - 1);

    state_t                   state_reg;
    logic [ADDR_W-1:0]        idx_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [X_W-1:0]    x_d_reg;
    logic                     valid_d_reg;
    logic [X_W-1:0]           y_data_reg;
    logic                     y_valid_reg;
    logic                     busy_reg;
    logic                     x_ready_reg;

    logic                     accept;
    logic signed [PRD_W-1:0]  prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic [X_W-1:0]           y_sat;

    assign accept = bus.x_valid && x_ready_reg;

    // ROM address goes out in the accept cycle so its data lines up with x_d_reg
    assign bus.rom_ce0      = accept;
    assign bus.rom_address0 = accept ? idx_reg : '0;

    assign prod     = $signed(bus.rom_q0) * x_d_reg;
    assign acc_next = valid_d_reg ? acc_reg + ACC_W'(prod) : acc_reg;

    mpc_mvmult_sat #(
        .ACC_W (ACC_W),
        .X_W   (X_W),
        .FRAC  (FRAC)
    ) u_sat (
        .acc (acc_next),
        .y   (y_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            acc_reg     <= '0;
            x_d_reg     <= '0;
            valid_d_reg <= 1'b0;
            y_data_reg  <= '0;
            y_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            x_ready_reg <= 1'b0;
        end else begin
            valid_d_reg <= accept;
            acc_reg     <= acc_next;
            if (accept) begin
                x_d_reg <= bus.x_data;
                idx_reg <= (idx_reg == LAST) ? '0 : idx_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg   <= RUN;
                        acc_reg     <= '0;
                        idx_reg     <= '0;
                        busy_reg    <= 1'b1;
                        x_ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept && idx_reg == LAST) begin
                        state_reg   <= DRAIN;
                        x_ready_reg <= 1'b0;
                    end
                end
                DRAIN: begin
                    // acc_next already folds in the final product here
                    state_reg   <= OUT;
                    y_data_reg  <= y_sat;
                    y_valid_reg <= 1'b1;
                end
                OUT: begin
                    if (bus.y_ready) begin
                        state_reg   <= IDLE;
                        y_valid_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.x_ready = x_ready_reg;
    assign bus.y_data  = y_data_reg;
    assign bus.y_valid = y_valid_reg;

endmodule

// File: tb/tb_mpc_mvmult_row_mac.sv
// Directed-vector bench for mpc_mvmult_row_mac with a behavioural 1-cycle ROM.
// Expected results depend on whether MPC_MVMULT_SAT_EN is defined.
module tb_mpc_mvmult_row_mac;
    import mpc_mvmult_pkg::*;

    // 18-bit coefficients so that +1.0 (0x10000) and -1.0 (0x30000) are both exact
    localparam int N      = 8;
    localparam int ADDR_W = 3;
    localparam int COEF_W = 18;
    localparam int X_W    = 32;
    localparam int FRAC   = 16;

    localparam logic [COEF_W-1:0] ONE_P = 18'h10000;
    localparam logic [COEF_W-1:0] ONE_N = 18'h30000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mpc_mvmult_row_mac_if #(.ADDR_W(ADDR_W), .COEF_W(COEF_W), .X_W(X_W)) bus ();

    mpc_mvmult_row_mac #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .COEF_W (COEF_W),
        .X_W    (X_W),
        .FRAC   (FRAC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [COEF_W-1:0] rom   [N];
    logic [X_W-1:0]    x_vec [N];

    always @(posedge clk) begin
        if (bus.rom_ce0) bus.rom_q0 <= rom[bus.rom_address0];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_rom(input logic [COEF_W-1:0] odd_val);
        for (int i = 0; i < N; i++) rom[i] = (i % 2 == 1) ? odd_val : '0;
    endtask

    task automatic send_row(input string tag, input bit gaps, input int stop_at);
        int k;
        int guard;
        bit v;
        bit acc_now;
        k = 0;
        guard = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (k < stop_at && guard < 200) begin
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.x_valid = v;
            bus.x_data  = v ? x_vec[k] : X_W'($urandom);
            @(negedge clk);
            acc_now = bus.x_valid && bus.x_ready;
            if (acc_now) begin
                chk({tag, "_addr"}, 64'(bus.rom_address0), 64'(k));
                chk({tag, "_ce"}, 64'(bus.rom_ce0), 64'(1));
            end
            @(posedge clk); #1;
            if (acc_now) k++;
            guard++;
        end
        bus.x_valid = 1'b0;
        if (k < stop_at) chk({tag, "_timeout"}, 64'(k), 64'(stop_at));
    endtask

    task automatic wait_y(input string tag, input logic [X_W-1:0] exp);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.y_valid && cnt < 10);
        chk({tag, "_lat"}, 64'(cnt), 64'(2));
        chk({tag, "_y"}, 64'(bus.y_data), 64'(exp));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
        $display("row %s y_data=0x%08h latency=%0d", tag, bus.y_data, cnt);
    endtask

    task automatic end_row(input string tag);
        bus.y_ready = 1'b1;
        @(posedge clk); #1;
        bus.y_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_idle_yv"}, 64'(bus.y_valid), 64'(0));
    endtask

    initial begin
        logic [X_W-1:0] sat_exp;
`ifdef MPC_MVMULT_SAT_EN
        sat_exp = 32'h7FFFFFFF;
`else
        sat_exp = 32'hFFFFFFFC;
`endif
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
        bus.y_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_y_data", 64'(bus.y_data), 64'(0));
        chk("rst_y_valid", 64'(bus.y_valid), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_x_ready", 64'(bus.x_ready), 64'(0));
        chk("rst_ce", 64'(bus.rom_ce0), 64'(0));
        chk("rst_addr", 64'(bus.rom_address0), 64'(0));
        @(posedge clk); #1;

        // 4 x (1.0 * 1.0) = 4.0
        load_rom(ONE_P);
        for (int i = 0; i < N; i++) x_vec[i] = 32'h00010000;
        send_row("ones", 1'b0, N);
        wait_y("ones", 32'h00040000);
        end_row("ones");

        // x_k = k: odd terms 1+3+5+7 = 16.0, with random bubbles
        for (int i = 0; i < N; i++) x_vec[i] = 32'(i) << 16;
        send_row("ramp", 1'b1, N);
        wait_y("ramp", 32'h00100000);
        end_row("ramp");

        // 4 x 0x7FFFFFFF overflows X_W: saturates or wraps
        for (int i = 0; i < N; i++) x_vec[i] = 32'h7FFFFFFF;
        send_row("big", 1'b0, N);
        wait_y("big", sat_exp);
        end_row("big");

        // Consumer stalls 5 cycles; a start pulse in OUT must be ignored
        for (int i = 0; i < N; i++) x_vec[i] = 32'h00010000;
        send_row("hold", 1'b0, N);
        wait_y("hold", 32'h00040000);
        for (int c = 0; c < 5; c++) begin
            bus.start = (c == 2);
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            chk("hold_yv", 64'(bus.y_valid), 64'(1));
            chk("hold_yd", 64'(bus.y_data), 64'(32'h00040000));
            chk("hold_busy", 64'(bus.busy), 64'(1));
            chk("hold_xr", 64'(bus.x_ready), 64'(0));
        end
        end_row("hold");

        // start coincident with the y handshake is dropped
        send_row("same", 1'b0, N);
        wait_y("same", 32'h00040000);
        bus.start   = 1'b1;
        bus.y_ready = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.y_ready = 1'b0;
        @(negedge clk);
        chk("same_busy0", 64'(bus.busy), 64'(0));
        @(negedge clk);
        chk("same_busy1", 64'(bus.busy), 64'(0));
        chk("same_xr", 64'(bus.x_ready), 64'(0));

        // Reset after four accepts discards the partial row
        @(posedge clk); #1;
        send_row("abort", 1'b0, 4);
        bus.x_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_y_data", 64'(bus.y_data), 64'(0));
        chk("abort_y_valid", 64'(bus.y_valid), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_x_ready", 64'(bus.x_ready), 64'(0));
        chk("abort_ce", 64'(bus.rom_ce0), 64'(0));
        chk("abort_addr", 64'(bus.rom_address0), 64'(0));
        @(posedge clk); #1;
        bus.x_valid = 1'b0;
        send_row("after", 1'b0, N);
        wait_y("after", 32'h00040000);
        end_row("after");

        // -1.0 at odd addresses gives -4.0
        load_rom(ONE_N);
        send_row("neg", 1'b0, N);
        wait_y("neg", 32'hFFFC0000);
        end_row("neg");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mpc_mvmult_row_mac.md
MPC_MVMULT_ROW_MAC -- requirements
Module: mpc_mvmult_row_mac

Interface
REQ-001 Parameter N, default 8: vector length and number of ROM coefficients per row.
REQ-002 Parameter ADDR_W, default 3: coefficient ROM address width, with N <= 2**ADDR_W.
REQ-003 Parameter COEF_W, default 17: signed coefficient width, Q1.16.
REQ-004 Parameter X_W, default 32: signed vector element and result width, Q16.16.
REQ-005 Parameter FRAC, default 16: coefficient fractional bits, removed after accumulation.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 start  in  1  one-cycle request to begin a row; honoured only in IDLE.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 x_data  in  X_W  vector element k, signed.
REQ-012 x_valid  in  1  x_data is valid.
REQ-013 x_ready  out  1  element accepted when x_valid && x_ready.
REQ-014 rom_address0  out  ADDR_W  coefficient ROM address.
REQ-015 rom_ce0  out  1  coefficient ROM read enable.
REQ-016 rom_q0  in  COEF_W  coefficient ROM data, 1-cycle registered read latency.
REQ-017 y_data  out  X_W  dot product of the row coefficients and the vector.
REQ-018 y_valid  out  1  y_data is valid.
REQ-019 y_ready  in  1  consumer accepts y when y_valid && y_ready.

Function
REQ-020 FSM states and transitions:
- IDLE -> RUN on start; clear accumulator; idx=0.
- RUN -> DRAIN when element N-1 is accepted.
- DRAIN -> OUT after one cycle.
- OUT -> IDLE on y_valid && y_ready.
REQ-021 x_ready = 1 only in RUN.
REQ-022 On each accept in RUN: rom_address0=idx, rom_ce0=1, x_data registered into x_d, valid_d=1, idx increments; otherwise rom_ce0=0 and valid_d=0.
REQ-023 In the cycle after an accept (valid_d=1): acc += sign-extend(rom_q0 * x_d); acc width COEF_W+X_W+clog2(N) bits, signed.
REQ-024 A cycle with x_valid low inserts a bubble; the result is independent of gap pattern.
REQ-025 Entering OUT: y_data = acc >>> FRAC (arithmetic, truncation toward -inf), reduced to X_W per REQ-031; y_valid=1.
REQ-026 Latency: y_valid rises exactly 2 cycles after the cycle element N-1 is accepted.
REQ-027 In OUT, y_data and y_valid are held stable until y_ready; start is ignored when not in IDLE.
REQ-028 start and y handshake in the same cycle: handshake completes, start ignored (state was OUT).
REQ-029 idx wraps to 0 after the last element; rom_address0 is never driven >= N while rom_ce0=1.

Reset
REQ-030 reset in any state, including mid-row:
- state=IDLE; idx, acc, x_d, valid_d cleared.
- Outputs to 0: y_data, y_valid, busy, x_ready, rom_ce0, rom_address0.
- Partial results are discarded.

Configuration
REQ-031 Macro MPC_MVMULT_SAT_EN:
- Defined: a shifted result above 0x7FFFFFFF saturates to 0x7FFFFFFF; below 0x80000000 it saturates to 0x80000000 (X_W=32).
- Undefined: low X_W bits are taken (two's-complement wrap).

Structure
REQ-032 Package mpc_mvmult_pkg holds:
- default widths (COEF_W, X_W, FRAC);
- the FSM state enum (IDLE, RUN, DRAIN, OUT);
- the accumulator width function.
REQ-033 Sub-module mpc_mvmult_sat, combinational, implements the shift and REQ-031 reduction. The coefficient ROM stays external.

Verification
REQ-034 ROM {0,1.0,0,1.0,0,1.0,0,1.0}, x all 0x00010000, no gaps -> y_data=0x00040000, y_valid 2 cycles after 8th accept.
REQ-035 Same ROM, x_k=k*0x00010000, random x_valid gaps -> y_data=0x00100000 (16.0).
REQ-036 Same ROM, x all 0x7FFFFFFF -> with MPC_MVMULT_SAT_EN y_data=0x7FFFFFFF; without, y_data=0xFFFFFFFC.
REQ-037 y_ready held low 5 cycles in OUT, start pulsed -> y_data and y_valid stable, no new row, busy=1; row completes on y_ready.
REQ-038 reset asserted after 4 accepts -> next cycle all outputs 0, IDLE; new row (REQ-034 stimulus) yields 0x00040000.
REQ-039 Negative check: coefficient word -1.0 (0x10000 interpreted as signed 17-bit) at odd addresses, x all 0x00010000 -> y_data=0xFFFC0000 (-4.0).
